// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with a
// scoreboard of registers that have a long-latency (port B) write in flight.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_valid,
  output logic        o_a_ready,
  input  logic [4:0]  i_a_waddr,
  input  logic [31:0] i_a_wdata,
  input  logic        i_b_valid,
  output logic        o_b_ready,
  input  logic [4:0]  i_b_waddr,
  input  logic [31:0] i_b_wdata,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd,
  output logic        o_issue_ready,
  input  logic [4:0]  i_rs1_raddr,
  input  logic [4:0]  i_rs2_raddr,
  output logic        o_raw_stall,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata,
  output logic [31:0] o_busy,
  output logic        o_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
  localparam logic [3:0]    SLIMIT  = 4'(STARVE_LIMIT);

  logic [31:0]   busy_q, busy_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [3:0]    starve_q, starve_d;
  logic          err_q, err_d;

  logic a_blk, a_elig, grant_a, grant_b, issue_acc, retire_dec;

  // Grant: A has priority unless B has waited STARVE_LIMIT cycles.
  always_comb begin
    a_blk   = (i_a_waddr != 5'd0) && busy_q[i_a_waddr];
    a_elig  = i_a_valid && !a_blk;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!i_rst) begin
      if (a_elig && i_b_valid) begin
        if (starve_q == SLIMIT) grant_b = 1'b1;
        else                    grant_a = 1'b1;
      end else if (a_elig) begin
        grant_a = 1'b1;
      end else if (i_b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  always_comb begin
    o_rd_waddr = 5'd0;
    o_rd_wdata = 32'd0;
    if (grant_a) begin
      o_rd_waddr = i_a_waddr;
      o_rd_wdata = i_a_wdata;
    end else if (grant_b) begin
      o_rd_waddr = i_b_waddr;
      o_rd_wdata = i_b_wdata;
    end
  end

  assign o_a_ready     = grant_a;
  assign o_b_ready     = grant_b;
  assign o_rd_wen      = (grant_a || grant_b) && (o_rd_waddr != 5'd0);
  assign o_issue_ready = !i_rst && (out_cnt_q < MAX_OUT) &&
                         ((i_issue_rd == 5'd0) || !busy_q[i_issue_rd]);
  assign issue_acc     = i_issue_valid && o_issue_ready;
  assign retire_dec    = grant_b && (out_cnt_q != '0);
  assign o_raw_stall   = ((i_rs1_raddr != 5'd0) && busy_q[i_rs1_raddr]) ||
                         ((i_rs2_raddr != 5'd0) && busy_q[i_rs2_raddr]);
  assign o_busy        = i_rst ? 32'd0 : busy_q;
  assign o_err         = i_rst ? 1'b0 : err_q;

  always_comb begin
    busy_d    = busy_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;
    starve_d  = starve_q;
    if (grant_b) begin
      busy_d[i_b_waddr] = 1'b0;
      if (out_cnt_q == '0) err_d = 1'b1;
      if ((i_b_waddr != 5'd0) && !busy_q[i_b_waddr]) err_d = 1'b1;
    end
    // Issue never targets a busy rd, so set and clear cannot collide.
    if (issue_acc && (i_issue_rd != 5'd0)) busy_d[i_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    case ({issue_acc, retire_dec})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
    if (grant_b || !i_b_valid)  starve_d = 4'd0;
    else if (starve_q < SLIMIT) starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q    <= 32'd0;
      out_cnt_q <= '0;
      starve_q  <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      out_cnt_q <= out_cnt_d;
      starve_q  <= starve_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: hand-computed expectations per cycle.
module tb_rf_wb_arbiter;

  logic        clk, rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_waddr, b_waddr, issue_rd, rs1, rs2, rd_waddr;
  logic [31:0] a_wdata, b_wdata, rd_wdata, busy;
  logic        issue_valid, issue_ready, raw_stall, rd_wen, err;

  int n_chk  = 0;
  int n_fail = 0;

  rf_wb_arbiter #(.STARVE_LIMIT(4), .MAX_OUTSTANDING(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_waddr(a_waddr), .i_a_wdata(a_wdata),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_waddr(b_waddr), .i_b_wdata(b_wdata),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_issue_ready(issue_ready),
    .i_rs1_raddr(rs1), .i_rs2_raddr(rs2), .o_raw_stall(raw_stall),
    .o_rd_wen(rd_wen), .o_rd_waddr(rd_waddr), .o_rd_wdata(rd_wdata),
    .o_busy(busy), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic exp_rdy, input string tag);
    issue_valid = 1'b1;
    issue_rd    = rd;
    settle();
    chk(tag, {31'd0, issue_ready}, {31'd0, exp_rdy});
    step();
    issue_valid = 1'b0;
  endtask

  task automatic retire(input logic [4:0] rd, input string tag);
    b_valid = 1'b1;
    b_waddr = rd;
    b_wdata = {27'd0, rd};
    settle();
    chk(tag, {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b1; a_waddr = 5'd5; a_wdata = 32'h1;
    b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 32'h0;
    issue_valid = 1'b1; issue_rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0;
    step();
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd0);
    chk("rst_wen", {31'd0, rd_wen}, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
    step();
    rst = 1'b0;
    step();

    // basic write
    a_valid = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF;
    settle();
    chk("basic_a_ready", {31'd0, a_ready}, 32'd1);
    chk("basic_wen", {31'd0, rd_wen}, 32'd1);
    chk("basic_waddr", {27'd0, rd_waddr}, 32'd5);
    chk("basic_wdata", rd_wdata, 32'hDEADBEEF);
    step();
    a_waddr = 5'd0; a_wdata = 32'h1234;
    settle();
    chk("x0_a_ready", {31'd0, a_ready}, 32'd1);
    chk("x0_wen", {31'd0, rd_wen}, 32'd0);
    step();
    a_valid = 1'b0;
    settle();
    chk("idle_waddr", {27'd0, rd_waddr}, 32'd0);
    chk("idle_wdata", rd_wdata, 32'd0);

    // scoreboard / RAW on rd 7
    rs1 = 5'd7;
    issue_valid = 1'b1; issue_rd = 5'd7;
    settle();
    chk("iss7_ready", {31'd0, issue_ready}, 32'd1);
    chk("iss7_raw_same_cycle", {31'd0, raw_stall}, 32'd0);
    step();
    issue_valid = 1'b0;
    settle();
    chk("iss7_raw", {31'd0, raw_stall}, 32'd1);
    chk("iss7_busy", busy, 32'h80);

    // starvation: A to r3 and B to r7 both valid
    a_valid = 1'b1; a_waddr = 5'd3; a_wdata = 32'h33;
    b_valid = 1'b1; b_waddr = 5'd7; b_wdata = 32'h77;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("starve_c%0d_a", c), {31'd0, a_ready}, 32'd1);
      chk($sformatf("starve_c%0d_b", c), {31'd0, b_ready}, 32'd0);
      step();
    end
    settle();
    chk("starve_c4_b", {31'd0, b_ready}, 32'd1);
    chk("starve_c4_a", {31'd0, a_ready}, 32'd0);
    chk("starve_c4_waddr", {27'd0, rd_waddr}, 32'd7);
    chk("starve_c4_wdata", rd_wdata, 32'h77);
    step();
    b_valid = 1'b1; b_waddr = 5'd7;
    settle();
    chk("starve_reset_a", {31'd0, a_ready}, 32'd1);
    chk("starve_reset_b", {31'd0, b_ready}, 32'd0);
    chk("ret7_busy", busy, 32'd0);
    chk("ret7_raw", {31'd0, raw_stall}, 32'd0);
    chk("ret7_err", {31'd0, err}, 32'd0);
    step();
    b_valid = 1'b0; a_valid = 1'b0; rs1 = 5'd0;

    // WAW block on r9
    issue(5'd9, 1'b1, "iss9_ready");
    a_valid = 1'b1; a_waddr = 5'd9; a_wdata = 32'h99;
    settle();
    chk("waw_a_blocked", {31'd0, a_ready}, 32'd0);
    chk("waw_wen", {31'd0, rd_wen}, 32'd0);
    step();
    chk("waw_a_blocked2", {31'd0, a_ready}, 32'd0);
    b_valid = 1'b1; b_waddr = 5'd9; b_wdata = 32'hB9;
    settle();
    chk("waw_b_ready", {31'd0, b_ready}, 32'd1);
    chk("waw_a_still", {31'd0, a_ready}, 32'd0);
    chk("waw_b_wdata", rd_wdata, 32'hB9);
    step();
    b_valid = 1'b0;
    settle();
    chk("waw_a_after", {31'd0, a_ready}, 32'd1);
    chk("waw_a_wdata", rd_wdata, 32'h99);
    chk("waw_err", {31'd0, err}, 32'd0);
    step();
    a_valid = 1'b0;

    // full and simultaneous issue/retire
    issue(5'd1, 1'b1, "full_iss1");
    issue(5'd2, 1'b1, "full_iss2");
    issue(5'd3, 1'b1, "full_iss3");
    issue(5'd4, 1'b1, "full_iss4");
    issue(5'd5, 1'b0, "full_iss5_refused");
    issue(5'd0, 1'b0, "full_iss0_refused");
    issue_valid = 1'b1; issue_rd = 5'd5;
    b_valid = 1'b1; b_waddr = 5'd1;
    settle();
    chk("full_retire_cycle_refuse", {31'd0, issue_ready}, 32'd0);
    chk("full_retire_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0; issue_valid = 1'b0;
    issue(5'd5, 1'b1, "after_retire_iss5");
    retire(5'd3, "ret3");
    issue_valid = 1'b1; issue_rd = 5'd0;
    b_valid = 1'b1; b_waddr = 5'd4;
    settle();
    chk("simul_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("simul_b_ready", {31'd0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0; issue_valid = 1'b0;
    rs2 = 5'd5;
    settle();
    chk("simul_busy", busy, 32'h24);
    chk("rs2_raw", {31'd0, raw_stall}, 32'd1);
    rs2 = 5'd0;
    issue(5'd2, 1'b0, "busy_rd_refused");
    issue(5'd10, 1'b1, "simul_cnt_iss10");
    issue(5'd11, 1'b0, "simul_cnt_full");
    chk("sb_err", {31'd0, err}, 32'd0);

    // drain, then retire with nothing outstanding
    retire(5'd2, "drain2");
    retire(5'd5, "drain5");
    retire(5'd10, "drain10");
    retire(5'd0, "drain_x0");
    chk("drain_busy", busy, 32'd0);
    chk("drain_err", {31'd0, err}, 32'd0);
    retire(5'd12, "err_b_ready");
    chk("err_set", {31'd0, err}, 32'd1);
    step();
    step();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // asynchronous reset mid-stream
    issue(5'd13, 1'b1, "pre_rst_iss13");
    a_valid = 1'b1; a_waddr = 5'd6; a_wdata = 32'h66;
    b_valid = 1'b1; b_waddr = 5'd13;
    issue_valid = 1'b1; issue_rd = 5'd14;
    settle();
    chk("pre_rst_busy", busy, 32'h2000);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_busy", busy, 32'd0);
    chk("arst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("arst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("arst_issue_ready", {31'd0, issue_ready}, 32'd0);
    chk("arst_wen", {31'd0, rd_wen}, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
    step();
    rst = 1'b0;
    settle();
    chk("post_rst_err", {31'd0, err}, 32'd0);
    chk("post_rst_busy", busy, 32'd0);
    issue_rd = 5'd13;
    settle();
    chk("post_rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 register file's single synchronous write port. Two producers share the port: the in-order pipeline write-back (port A) and a long-latency unit such as a load or mul/div (port B). Both use valid/ready handshakes. The block also tracks which architectural registers have a port-B write in flight, so the pipeline can stall on RAW and WAW hazards. It sits between the producers and the register file write port (wen/waddr/wdata).

## Interface
- STARVE_LIMIT, 4: consecutive cycles port B may be denied while valid before it takes priority (1..15).
- MAX_OUTSTANDING, 4: maximum issued-but-not-written port-B operations (1..31).

- i_clk  in  1  global clock
- i_rst  in  1  reset, asynchronous, active-high
- i_a_valid  in  1  pipeline write-back request
- o_a_ready  out  1  port A granted this cycle
- i_a_waddr  in  5  port A destination register
- i_a_wdata  in  32  port A data
- i_b_valid  in  1  long-latency write-back request
- o_b_ready  out  1  port B granted this cycle
- i_b_waddr  in  5  port B destination register
- i_b_wdata  in  32  port B data
- i_issue_valid  in  1  long-latency op issuing, reserves its destination
- i_issue_rd  in  5  destination of the issuing op
- o_issue_ready  out  1  issue accepted
- i_rs1_raddr, i_rs2_raddr  in  5 each  source registers of the instruction in decode
- o_raw_stall  out  1  a source register has a pending port-B write
- o_rd_wen  out  1  register file write enable
- o_rd_waddr  out  5  register file write address
- o_rd_wdata  out  32  register file write data
- o_busy  out  32  per-register pending bitmap; bit 0 is always 0
- o_err  out  1  sticky protocol-error flag

## Operation
- **State**
  - busy[31:1]
  - out_cnt, width clog2(MAX_OUTSTANDING+1)
  - starve_cnt, 4 bits
  - err
- **Transfers**
  - A transfer: i_a_valid && o_a_ready.
  - B transfer: i_b_valid && o_b_ready.
  - At most one transfer occurs per cycle.
- **WAW block:** a_blk = i_a_waddr != 0 && busy[i_a_waddr]. A blocked request is never granted.
- **Grant (combinational)**
  - Only A is eligible (valid, not blocked): grant A.
  - Only B is valid: grant B.
  - Both eligible: grant A, unless starve_cnt == STARVE_LIMIT, in which case grant B.
- **starve_cnt**
  - Cleared to 0 on a B transfer or when i_b_valid = 0.
  - Otherwise increments, saturating at STARVE_LIMIT.
- **Producer rule:** producers hold valid, address and data stable until ready. Ready never depends on a producer's own ready.
- **Write port (combinational)**
  - o_rd_waddr and o_rd_wdata come from the granted port; they are 0 when neither port is granted.
  - o_rd_wen = transfer && o_rd_waddr != 0. A write to x0 completes the handshake without writing.
- **Issue**
  - o_issue_ready = !i_rst && out_cnt < MAX_OUTSTANDING && (i_issue_rd == 0 || !busy[i_issue_rd]).
  - On an accepted issue: out_cnt += 1, and busy[i_issue_rd] is set if rd != 0.
- **Retire:** on a B transfer, out_cnt -= 1 and busy[i_b_waddr] is cleared.
- **Simultaneous issue and retire:** out_cnt is unchanged. Busy set and clear apply to their respective bits. The same bit cannot be both set and cleared: issue to a busy rd is refused.
- **Hazard:** o_raw_stall = (rs1 != 0 && busy[rs1]) || (rs2 != 0 && busy[rs2]). The block does not bypass.
- **Errors (set err, sticky until reset)**
  - B transfer while out_cnt == 0; out_cnt stays 0.
  - B transfer to a nonzero register whose busy bit is clear. The write still proceeds.

## Timing
- **Reset**
  - Asynchronous assertion clears busy, out_cnt, starve_cnt and err.
  - While i_rst = 1, o_a_ready, o_b_ready, o_issue_ready and o_rd_wen are forced to 0; o_busy = 0; o_err = 0.
  - Deassertion takes effect at the next rising edge. Any handshake in progress when reset is asserted is dropped.
- **Latency**
  - Grant, write-port outputs and o_raw_stall are combinational, same cycle as the inputs.
  - The register file captures the write at the same edge that completes the handshake.
- **State updates:** busy, out_cnt and starve_cnt update at the rising edge after a transfer or issue. o_busy and o_raw_stall reflect the new value in the following cycle.
- **Starvation bound:** with A continuously eligible, a waiting B is granted no later than the (STARVE_LIMIT+1)-th cycle of its request.
- **Full:** when out_cnt == MAX_OUTSTANDING, o_issue_ready = 0 until a B retire edge. The retire cycle itself still refuses the issue, because the check uses the registered count.

## Test plan
- **Basic write:** A valid, waddr 5, data 0xDEADBEEF, B idle → o_a_ready = 1, o_rd_wen = 1, o_rd_waddr = 5 the same cycle.
- **Starvation:** A and B both valid continuously, STARVE_LIMIT = 4 → A granted in cycles 0-3, B granted in cycle 4, starve_cnt back to 0.
- **Scoreboard and RAW:**
  - Issue rd 7, then read rs1 = 7 → o_raw_stall = 1 and o_busy[7] = 1 from the next cycle.
  - B writes 7 → both clear the cycle after the write.
- **WAW block:** busy[9] set, A valid to 9 → o_a_ready = 0 until B retires 9; A is granted the following cycle.
- **Full and simultaneous:**
  - Four issues with MAX_OUTSTANDING = 4 → o_issue_ready = 0.
  - Issue and B retire in the same cycle → out_cnt unchanged.
  - An issue to x0 is accepted and no busy bit is set.
- **Errors and reset:**
  - B transfer with out_cnt = 0 → o_err = 1 and stays 1.
  - Asynchronous i_rst mid-stream → o_err, o_busy and the ready outputs are 0 immediately.
